pcie_tx_arbiter: RTL and testbench

//  Packet-level arbiter for the single 64-bit TX AXI-stream TLP channel of xilinx_pcie_slot.

---
 rtl/pcie_tx_pkg.sv | 24 ++
 rtl/rr_pick.sv | 50 +++++
 rtl/pcie_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tx_pkg.sv
// Shared definitions for the PCIe TX arbiter slice.
//  - State encoding for the arbiter FSM.
//  - AXI-stream field widths of the core's s_axis_tx_* port.
//  - Width of the grant index / round-robin pointer (covers up to 8 requesters).
//  - Helper to size the per-packet beat counter.
package pcie_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_CFG  = 2'd2
   } state_e;

   localparam int TDATA_W = 64;
   localparam int TKEEP_W = 8;
   localparam int TUSER_W = 4;
   localparam int GRANT_W = 3;

   // Counter must be able to hold the value max_beats itself (saturation point).
   function automatic int cnt_width(input int max_beats);
      return $clog2(max_beats + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker, purely combinational.
// Scans the valid vector starting at rr_ptr+1 (mod N) and returns the first
// set requester both as a one-hot vector and as a binary index.
// Ports:
//  valid        in   N        request vector
//  rr_ptr       in   GRANT_W  last served requester
//  pick_onehot  out  N        one-hot winner, all zero when nothing is valid
//  pick_idx     out  GRANT_W  winner index, zero when nothing is valid
module rr_pick
   import pcie_tx_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]       valid,
   input  logic [GRANT_W-1:0] rr_ptr,
   output logic [N-1:0]       pick_onehot,
   output logic [GRANT_W-1:0] pick_idx
);

   localparam int PW = GRANT_W + 1;

   logic [PW-1:0] pos_s;
   logic          hit_s;
   logic          found_s;

   // Walk positions rr_ptr+1 .. rr_ptr+N; the first valid one wins.
   always_comb begin
      pick_onehot = '0;
      pick_idx    = '0;
      found_s     = 1'b0;
      pos_s       = '0;
      hit_s       = 1'b0;
      for (int k = 1; k <= N; k++) begin
         // rr_ptr < N and k <= N, so a single subtraction wraps correctly.
         pos_s = {1'b0, rr_ptr} + PW'(k);
         if (pos_s >= PW'(N)) begin
            pos_s = pos_s - PW'(N);
         end else begin
            pos_s = pos_s;
         end
         for (int i = 0; i < N; i++) begin
            hit_s          = !found_s && valid[i] && (pos_s == PW'(i));
            pick_onehot[i] = pick_onehot[i] | hit_s;
            pick_idx       = hit_s ? GRANT_W'(i) : pick_idx;
            found_s        = found_s | hit_s;
         end
      end
   end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-level arbiter for the single 64-bit TX AXI-stream channel of the PCIe slot.
// N requester engines share the channel round-robin; a TLP is never split or
// interleaved. The core can claim the channel between packets via tx_cfg_req.
// Ports:
//  user_clk, user_reset              clock, async active-high reset
//  req_tdata/tkeep/tuser/tlast/tvalid requester i in slice i of each bus
//  req_tready                         per-requester accept
//  s_axis_tx_*                        AXI-stream towards the core
//  tx_cfg_req / tx_cfg_gnt            core channel request / yield
//  grant_idx                          owner of the channel while BUSY
//  err_overlong                       sticky, an open packet reached MAX_BEATS beats
module pcie_tx_arbiter
   import pcie_tx_pkg::*;
#(
   parameter int N         = 2,
   parameter int MAX_BEATS = 512
) (
   input  logic                   user_clk,
   input  logic                   user_reset,
   input  logic [N*TDATA_W-1:0]   req_tdata,
   input  logic [N*TKEEP_W-1:0]   req_tkeep,
   input  logic [N*TUSER_W-1:0]   req_tuser,
   input  logic [N-1:0]           req_tlast,
   input  logic [N-1:0]           req_tvalid,
   output logic [N-1:0]           req_tready,
   output logic [TDATA_W-1:0]     s_axis_tx_tdata,
   output logic [TKEEP_W-1:0]     s_axis_tx_tkeep,
   output logic [TUSER_W-1:0]     s_axis_tx_tuser,
   output logic                   s_axis_tx_tlast,
   output logic                   s_axis_tx_tvalid,
   input  logic                   s_axis_tx_tready,
   input  logic                   tx_cfg_req,
   output logic                   tx_cfg_gnt,
   output logic [GRANT_W-1:0]     grant_idx,
   output logic                   err_overlong
);

   localparam int                CNT_W   = cnt_width(MAX_BEATS);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BEATS);
   // A non-last beat moving while the count already sits here brings it to MAX_BEATS.
   localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(MAX_BEATS - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   state_e               state_r;
   logic [GRANT_W-1:0]   grant_r;
   logic [GRANT_W-1:0]   rr_ptr_r;
   logic [CNT_W-1:0]     beat_cnt_r;
   logic                 err_r;
   logic                 cfg_gnt_r;

   logic [N-1:0]         pick_onehot_s;
   logic [GRANT_W-1:0]   pick_idx_s;
   logic                 pick_any_s;
   logic                 beat_fire_s;

   rr_pick #(
      .N (N)
   ) u_rr_pick (
      .valid       (req_tvalid),
      .rr_ptr      (rr_ptr_r),
      .pick_onehot (pick_onehot_s),
      .pick_idx    (pick_idx_s)
   );

   assign pick_any_s   = |pick_onehot_s;
   assign beat_fire_s  = s_axis_tx_tvalid & s_axis_tx_tready;
   assign tx_cfg_gnt   = cfg_gnt_r;
   assign grant_idx    = grant_r;
   assign err_overlong = err_r;

   // Output mux: only the granted requester is connected, and only while BUSY,
   // so IDLE/CFG (and reset, which forces IDLE) present an all-zero channel.
   always_comb begin
      s_axis_tx_tdata  = '0;
      s_axis_tx_tkeep  = '0;
      s_axis_tx_tuser  = '0;
      s_axis_tx_tlast  = 1'b0;
      s_axis_tx_tvalid = 1'b0;
      req_tready       = '0;
      for (int i = 0; i < N; i++) begin
         if ((state_r == ST_BUSY) && (grant_r == GRANT_W'(i))) begin
            s_axis_tx_tdata  = req_tdata[i*TDATA_W +: TDATA_W];
            s_axis_tx_tkeep  = req_tkeep[i*TKEEP_W +: TKEEP_W];
            s_axis_tx_tuser  = req_tuser[i*TUSER_W +: TUSER_W];
            s_axis_tx_tlast  = req_tlast[i];
            s_axis_tx_tvalid = req_tvalid[i];
            req_tready[i]    = s_axis_tx_tready;
         end else begin
            req_tready[i]    = 1'b0;
         end
      end
   end

   // Arbiter FSM, beat counter, round-robin pointer and sticky error.
   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         state_r    <= ST_IDLE;
         grant_r    <= '0;
         rr_ptr_r   <= GRANT_W'(N - 1);
         beat_cnt_r <= '0;
         err_r      <= 1'b0;
         cfg_gnt_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // Core request takes priority over any pending requester.
               if (tx_cfg_req) begin
                  state_r   <= ST_CFG;
                  cfg_gnt_r <= 1'b1;
               end else if (pick_any_s) begin
                  state_r    <= ST_BUSY;
                  grant_r    <= pick_idx_s;
                  beat_cnt_r <= '0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               // tx_cfg_req is deliberately not looked at until the packet ends.
               if (beat_fire_s) begin
                  if (s_axis_tx_tlast) begin
                     rr_ptr_r   <= grant_r;
                     beat_cnt_r <= '0;
                     grant_r    <= '0;
                     state_r    <= ST_IDLE;
                  end else begin
                     if (beat_cnt_r != CNT_MAX) begin
                        beat_cnt_r <= beat_cnt_r + CNT_ONE;
                     end else begin
                        beat_cnt_r <= beat_cnt_r;
                     end
                     // Grant is kept; the packet still runs to its tlast.
                     if (beat_cnt_r >= CNT_LIM) begin
                        err_r <= 1'b1;
                     end else begin
                        err_r <= err_r;
                     end
                  end
               end else begin
                  state_r <= ST_BUSY;
               end
            end
            ST_CFG: begin
               if (!tx_cfg_req) begin
                  state_r   <= ST_IDLE;
                  cfg_gnt_r <= 1'b0;
               end else begin
                  state_r <= ST_CFG;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               grant_r    <= '0;
               beat_cnt_r <= '0;
               cfg_gnt_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
module tb_pcie_tx_arbiter;

   localparam int N    = 2;
   localparam int MAXB = 4;

   logic            user_clk = 1'b0;
   logic            user_reset;
   logic [N*64-1:0] req_tdata;
   logic [N*8-1:0]  req_tkeep;
   logic [N*4-1:0]  req_tuser;
   logic [N-1:0]    req_tlast;
   logic [N-1:0]    req_tvalid;
   logic [N-1:0]    req_tready;
   logic [63:0]     s_axis_tx_tdata;
   logic [7:0]      s_axis_tx_tkeep;
   logic [3:0]      s_axis_tx_tuser;
   logic            s_axis_tx_tlast;
   logic            s_axis_tx_tvalid;
   logic            s_axis_tx_tready;
   logic            tx_cfg_req;
   logic            tx_cfg_gnt;
   logic [2:0]      grant_idx;
   logic            err_overlong;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic [3:0]  user;
      logic        last;
      logic [2:0]  grant;
   } beat_t;

   beat_t q0[$];
   beat_t q1[$];
   beat_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   pcie_tx_arbiter #(
      .N         (N),
      .MAX_BEATS (MAXB)
   ) dut (
      .user_clk         (user_clk),
      .user_reset       (user_reset),
      .req_tdata        (req_tdata),
      .req_tkeep        (req_tkeep),
      .req_tuser        (req_tuser),
      .req_tlast        (req_tlast),
      .req_tvalid       (req_tvalid),
      .req_tready       (req_tready),
      .s_axis_tx_tdata  (s_axis_tx_tdata),
      .s_axis_tx_tkeep  (s_axis_tx_tkeep),
      .s_axis_tx_tuser  (s_axis_tx_tuser),
      .s_axis_tx_tlast  (s_axis_tx_tlast),
      .s_axis_tx_tvalid (s_axis_tx_tvalid),
      .s_axis_tx_tready (s_axis_tx_tready),
      .tx_cfg_req       (tx_cfg_req),
      .tx_cfg_gnt       (tx_cfg_gnt),
      .grant_idx        (grant_idx),
      .err_overlong     (err_overlong)
   );

   always #5 user_clk = ~user_clk;

   // Sample point: after the monitor at the falling edge has run.
   task automatic sample();
      @(negedge user_clk);
      #1;
   endtask

   // Drive point: just after the rising edge.
   task automatic edge_step();
      @(posedge user_clk);
      #1;
   endtask

   // Queue one packet on requester r and its expected beats on the scoreboard.
   task automatic add_pkt(input int r, input int nb, input logic [7:0] last_keep);
      beat_t b;
      for (int k = 0; k < nb; k++) begin
         b.data  = {$urandom, $urandom};
         b.keep  = (k == nb - 1) ? last_keep : 8'hFF;
         b.user  = 4'($urandom_range(0, 15));
         b.last  = (k == nb - 1);
         b.grant = 3'(r);
         if (r == 0) q0.push_back(b);
         else        q1.push_back(b);
         exp_q.push_back(b);
      end
   endtask

   // Requester-side drivers: present queue heads, pop on handshake.
   initial begin : drivers
      logic f0;
      logic f1;
      forever begin
         @(negedge user_clk);
         f0 = req_tvalid[0] & req_tready[0];
         f1 = req_tvalid[1] & req_tready[1];
         @(posedge user_clk);
         #1;
         if (f0 && q0.size() > 0) void'(q0.pop_front());
         if (f1 && q1.size() > 0) void'(q1.pop_front());
         if (q0.size() > 0) begin
            req_tdata[63:0] = q0[0].data;
            req_tkeep[7:0]  = q0[0].keep;
            req_tuser[3:0]  = q0[0].user;
            req_tlast[0]    = q0[0].last;
            req_tvalid[0]   = 1'b1;
         end else begin
            req_tvalid[0]   = 1'b0;
            req_tlast[0]    = 1'b0;
         end
         if (q1.size() > 0) begin
            req_tdata[127:64] = q1[0].data;
            req_tkeep[15:8]   = q1[0].keep;
            req_tuser[7:4]    = q1[0].user;
            req_tlast[1]      = q1[0].last;
            req_tvalid[1]     = 1'b1;
         end else begin
            req_tvalid[1]     = 1'b0;
            req_tlast[1]      = 1'b0;
         end
      end
   end

   // Core-side monitor: every beat that moves is checked against the scoreboard.
   initial begin : monitor
      beat_t       e;
      logic [79:0] act;
      logic [79:0] expv;
      forever begin
         @(negedge user_clk);
         if (s_axis_tx_tvalid === 1'b1 && s_axis_tx_tready === 1'b1) begin
            n_checks++;
            act = {grant_idx, s_axis_tx_tlast, s_axis_tx_tuser, s_axis_tx_tkeep, s_axis_tx_tdata};
            if (exp_q.size() == 0) begin
               $display("FAIL beat_unexpected: got %h, required no beat", act);
            end else begin
               e    = exp_q.pop_front();
               expv = {e.grant, e.last, e.user, e.keep, e.data};
               if (act !== expv) $display("FAIL beat: got %h, required %h", act, expv);
               else n_pass++;
            end
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int cyc = 0;
      while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && cyc < budget) begin
         sample();
         cyc++;
      end
      sample();
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      else n_pass++;
   endtask

   // Poll until exactly 'left' beats remain on the scoreboard.
   task automatic wait_left(input string name, input int left);
      int cyc = 0;
      while (exp_q.size() != left && cyc < 30) begin
         sample();
         cyc++;
      end
      n_checks++;
      if (exp_q.size() != left)
         $display("FAIL %s_progress: %0d beats outstanding, required %0d", name, exp_q.size(), left);
      else n_pass++;
   endtask

   task automatic test_reset();
      logic [7:0] act;
      user_reset       = 1'b1;
      s_axis_tx_tready = 1'b1;
      tx_cfg_req       = 1'b0;
      sample();
      sample();
      act = {s_axis_tx_tvalid, req_tready, tx_cfg_gnt, grant_idx, err_overlong};
      n_checks++;
      if (act !== 8'h00) $display("FAIL reset_outputs: got %b, required 00000000", act);
      else n_pass++;
      edge_step();
      user_reset = 1'b0;
   endtask

   task automatic test_single();
      sample();
      add_pkt(0, 3, 8'h0F);
      sample();   // driver presenting, arbiter still IDLE
      n_checks++;
      if (s_axis_tx_tvalid !== 1'b0) $display("FAIL single_idle_cycle: tvalid %b, required 0", s_axis_tx_tvalid);
      else n_pass++;
      sample();   // grant taken, first beat visible
      n_checks++;
      if (s_axis_tx_tvalid !== 1'b1) $display("FAIL single_first_beat: tvalid %b, required 1", s_axis_tx_tvalid);
      else n_pass++;
      wait_drain("single", 20);
      n_checks++;
      if ({s_axis_tx_tvalid, req_tready} !== 3'b000)
         $display("FAIL single_back_idle: got %b, required 000", {s_axis_tx_tvalid, req_tready});
      else n_pass++;
   endtask

   task automatic test_round_robin();
      edge_step();
      user_reset = 1'b1;
      edge_step();
      user_reset = 1'b0;
      sample();
      add_pkt(0, 2, 8'hFF);
      add_pkt(1, 2, 8'h03);
      add_pkt(0, 2, 8'h1F);
      add_pkt(1, 2, 8'hFF);
      wait_drain("round_robin", 40);
   endtask

   task automatic test_backpressure();
      sample();
      add_pkt(1, 3, 8'h3F);
      wait_left("backpressure", 2);
      edge_step();
      s_axis_tx_tready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         sample();
         n_checks++;
         if ({s_axis_tx_tvalid, req_tready, grant_idx, s_axis_tx_tdata} !== {1'b1, 2'b00, 3'd1, exp_q[0].data})
            $display("FAIL backpressure_hold: cycle %0d got tvalid %b ready %b grant %0d data %h, required 1 00 1 %h",
                     c, s_axis_tx_tvalid, req_tready, grant_idx, s_axis_tx_tdata, exp_q[0].data);
         else n_pass++;
      end
      edge_step();
      s_axis_tx_tready = 1'b1;
      wait_drain("backpressure", 20);
   endtask

   task automatic test_cfg_boundary();
      int cyc = 0;
      sample();
      add_pkt(1, 3, 8'hFF);
      wait_left("cfg_first", 2);
      add_pkt(0, 2, 8'h0F);
      edge_step();
      tx_cfg_req = 1'b1;
      while (tx_cfg_gnt !== 1'b1 && cyc < 20) begin
         sample();
         cyc++;
      end
      n_checks++;
      if (tx_cfg_gnt !== 1'b1 || exp_q.size() != 2)
         $display("FAIL cfg_after_tlast: gnt %b with %0d beats outstanding, required 1 with 2", tx_cfg_gnt, exp_q.size());
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
         sample();
         n_checks++;
         if ({tx_cfg_gnt, s_axis_tx_tvalid, req_tready} !== 4'b1000)
            $display("FAIL cfg_window: got %b, required 1000", {tx_cfg_gnt, s_axis_tx_tvalid, req_tready});
         else n_pass++;
      end
      edge_step();
      tx_cfg_req = 1'b0;
      sample();
      sample();
      n_checks++;
      if (tx_cfg_gnt !== 1'b0) $display("FAIL cfg_release: gnt %b, required 0", tx_cfg_gnt);
      else n_pass++;
      wait_drain("cfg", 20);
   endtask

   task automatic test_overlong();
      int   moved;
      logic want;
      sample();
      add_pkt(0, 6, 8'hFF);
      for (int c = 0; c < 14; c++) begin
         sample();
         moved = 6 - exp_q.size() - ((s_axis_tx_tvalid & s_axis_tx_tready) ? 1 : 0);
         want  = (moved >= MAXB);
         n_checks++;
         if (err_overlong !== want)
            $display("FAIL overlong: after %0d beats err %b, required %b", moved, err_overlong, want);
         else n_pass++;
      end
      wait_drain("overlong", 10);
   endtask

   task automatic test_reset_mid();
      logic [71:0] act;
      sample();
      add_pkt(1, 3, 8'hFF);
      wait_left("reset_mid", 2);
      edge_step();
      user_reset = 1'b1;
      #1;
      act = {s_axis_tx_tvalid, req_tready, tx_cfg_gnt, grant_idx, err_overlong, s_axis_tx_tdata};
      n_checks++;
      if (act !== 72'h0) $display("FAIL reset_mid_outputs: got %h, required 0", act);
      else n_pass++;
      sample();
      q0.delete();
      q1.delete();
      exp_q.delete();
      add_pkt(0, 2, 8'hFF);
      add_pkt(1, 2, 8'h07);
      sample();
      sample();
      edge_step();
      user_reset = 1'b0;
      wait_drain("reset_rearb", 30);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : main
      user_reset       = 1'b1;
      req_tdata        = '0;
      req_tkeep        = '0;
      req_tuser        = '0;
      req_tlast        = '0;
      req_tvalid       = '0;
      s_axis_tx_tready = 1'b1;
      tx_cfg_req       = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_cfg_boundary();
      test_overlong();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
